// File: rtl/nn_pkg.sv
// Shared geometry, thresholds and types for the green-mask scan
// and the classifier that consumes its mask.
package nn_pkg;

  localparam int HEIGHT_DEF = 20;
  localparam int WIDTH_DEF  = 30;
  localparam int DEPTH_DEF  = 3;
  localparam int N_DEF      = HEIGHT_DEF * WIDTH_DEF * DEPTH_DEF;
  localparam int ADDR_W_DEF = 11;

  localparam logic [7:0] LOWER_0_DEF = 8'd18;
  localparam logic [7:0] LOWER_1_DEF = 8'd25;
  localparam logic [7:0] LOWER_2_DEF = 8'd25;
  localparam logic [7:0] UPPER_0_DEF = 8'd43;
  localparam logic [7:0] UPPER_1_DEF = 8'd255;
  localparam logic [7:0] UPPER_2_DEF = 8'd255;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  typedef logic [HEIGHT_DEF-1:0][WIDTH_DEF-1:0] mask_t;

endpackage

// File: rtl/green_mask_builder_if.sv
// Scan control, buffer read port and mask result bundle.
// master is the mask builder, slave is its environment.
interface green_mask_builder_if
  import nn_pkg::*;
#(
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  localparam int GW = $clog2(HEIGHT * WIDTH + 1);

  logic                         start;
  logic [ADDR_W-1:0]            rd_addr;
  logic [7:0]                   rd_data;
  logic                         busy;
  logic                         done;
  logic [HEIGHT-1:0][WIDTH-1:0] mask;
  logic                         mask_valid;
  logic [GW-1:0]                green_count;

  modport master (
    input  start,
    input  rd_data,
    output rd_addr,
    output busy,
    output done,
    output mask,
    output mask_valid,
    output green_count
  );

  modport slave (
    output start,
    output rd_data,
    input  rd_addr,
    input  busy,
    input  done,
    input  mask,
    input  mask_valid,
    input  green_count
  );

endinterface

// File: rtl/green_range_check.sv
// Inclusive unsigned bounds check of one byte against the
// limits of the channel it belongs to.
module green_range_check
  import nn_pkg::*;
#(
  parameter logic [7:0] LOWER_0 = LOWER_0_DEF,
  parameter logic [7:0] LOWER_1 = LOWER_1_DEF,
  parameter logic [7:0] LOWER_2 = LOWER_2_DEF,
  parameter logic [7:0] UPPER_0 = UPPER_0_DEF,
  parameter logic [7:0] UPPER_1 = UPPER_1_DEF,
  parameter logic [7:0] UPPER_2 = UPPER_2_DEF
) (
  input  logic [7:0] px,
  input  logic [1:0] ch,
  output logic       in_range
);

  logic [7:0] lo;
  logic [7:0] hi;

  // Pick the bound pair; an unused channel code never matches.
  always_comb begin
    lo = 8'hff;
    hi = 8'h00;
    unique case (1'b1)
      (ch == 2'd0): begin lo = LOWER_0; hi = UPPER_0; end
      (ch == 2'd1): begin lo = LOWER_1; hi = UPPER_1; end
      (ch == 2'd2): begin lo = LOWER_2; hi = UPPER_2; end
      default: ;
    endcase
  end

  assign in_range = (px >= lo) && (px <= hi);

endmodule

// File: rtl/green_mask_builder.sv
// Scans the capture buffer once per start and builds the
// thresholded green mask plus its population count.
module green_mask_builder
  import nn_pkg::*;
#(
  parameter int         HEIGHT  = HEIGHT_DEF,
  parameter int         WIDTH   = WIDTH_DEF,
  parameter int         DEPTH   = DEPTH_DEF,
  parameter int         ADDR_W  = ADDR_W_DEF,
  parameter logic [7:0] LOWER_0 = LOWER_0_DEF,
  parameter logic [7:0] LOWER_1 = LOWER_1_DEF,
  parameter logic [7:0] LOWER_2 = LOWER_2_DEF,
  parameter logic [7:0] UPPER_0 = UPPER_0_DEF,
  parameter logic [7:0] UPPER_1 = UPPER_1_DEF,
  parameter logic [7:0] UPPER_2 = UPPER_2_DEF
) (
  input logic                  slow_clk,
  input logic                  dbnc_rst,
  green_mask_builder_if.master bus
);

  localparam int N  = HEIGHT * WIDTH * DEPTH;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int GW = $clog2(HEIGHT * WIDTH + 1);

  state_t                       state;
  logic [ADDR_W-1:0]            rd_addr;
  logic                         busy;
  logic                         done;
  logic [HEIGHT-1:0][WIDTH-1:0] mask;
  logic                         mask_valid;
  logic [GW-1:0]                cnt;

  // addr_vld: rd_addr carries an issued address this cycle.
  // data_vld: rd_data carries the byte for last cycle's address.
  logic       addr_vld;
  logic       data_vld;
  logic [1:0] ch;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic       acc;
  logic       in_rng;
  logic       flag;
  logic       px_end;
  logic       last_px;

  green_range_check #(
    .LOWER_0(LOWER_0), .LOWER_1(LOWER_1), .LOWER_2(LOWER_2),
    .UPPER_0(UPPER_0), .UPPER_1(UPPER_1), .UPPER_2(UPPER_2)
  ) u_chk (
    .px      (bus.rd_data),
    .ch      (ch),
    .in_range(in_rng)
  );

  assign flag    = acc & in_rng;
  assign px_end  = (ch == 2'(DEPTH - 1));
  assign last_px = px_end
                && (row == RW'(HEIGHT - 1))
                && (col == CW'(WIDTH - 1));

  // Issue FSM plus the one-deep consume pipeline behind it.
  always_ff @(posedge slow_clk or posedge dbnc_rst) begin
    if (dbnc_rst) begin
      state      <= IDLE;
      rd_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mask       <= '0;
      mask_valid <= 1'b0;
      cnt        <= '0;
      addr_vld   <= 1'b0;
      data_vld   <= 1'b0;
      ch         <= '0;
      col        <= '0;
      row        <= '0;
      acc        <= 1'b1;
    end else begin
      done     <= 1'b0;
      data_vld <= addr_vld;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= SCAN;
            rd_addr    <= '0;
            addr_vld   <= 1'b1;
            busy       <= 1'b1;
            mask       <= '0;
            mask_valid <= 1'b0;
            cnt        <= '0;
            ch         <= '0;
            col        <= '0;
            row        <= '0;
            acc        <= 1'b1;
          end
        end
        SCAN: begin
          rd_addr <= rd_addr + ADDR_W'(1);
          if (rd_addr == ADDR_W'(N - 2)) state <= DRAIN;
        end
        DRAIN: addr_vld <= 1'b0;
        default: state <= IDLE;
      endcase
      if (data_vld) begin
        if (px_end) begin
          mask[row][col] <= flag;
          if (flag) cnt <= cnt + GW'(1);
          acc <= 1'b1;
          ch  <= '0;
          if (col == CW'(WIDTH - 1)) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end else begin
          acc <= flag;
          ch  <= ch + 2'd1;
        end
        if (last_px) begin
          state      <= IDLE;
          rd_addr    <= '0;
          busy       <= 1'b0;
          done       <= 1'b1;
          mask_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.rd_addr     = rd_addr;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.mask        = mask;
  assign bus.mask_valid  = mask_valid;
  assign bus.green_count = cnt;

endmodule

// File: tb/tb_green_mask_builder.sv
// Scoreboard bench for green_mask_builder: a byte-buffer model
// feeds the scan, expected masks are queued at each start.
module tb_green_mask_builder;
  import nn_pkg::*;

  localparam int N   = N_DEF;
  localparam int LAT = N + 1;
  localparam int NPX = HEIGHT_DEF * WIDTH_DEF;

  typedef struct packed {
    mask_t      m;
    logic [9:0] c;
  } exp_t;

  logic slow_clk;
  logic dbnc_rst;
  logic [7:0] mem [N];
  exp_t exp_q[$];
  exp_t ex;
  int n_checks;
  int n_fail;

  green_mask_builder_if bus ();

  green_mask_builder dut (
    .slow_clk(slow_clk),
    .dbnc_rst(dbnc_rst),
    .bus     (bus)
  );

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  // Synchronous read buffer: data registered on the address edge.
  always @(posedge slow_clk)
    bus.rd_data <= mem[bus.rd_addr];

  function automatic exp_t model();
    exp_t e;
    int b0, b1, b2;
    e = '0;
    for (int p = 0; p < NPX; p++) begin
      b0 = int'(mem[3*p]);
      b1 = int'(mem[3*p+1]);
      b2 = int'(mem[3*p+2]);
      if (b0 >= 18 && b0 <= 43 && b1 >= 25 && b1 <= 255
          && b2 >= 25 && b2 <= 255) begin
        e.m[p / WIDTH_DEF][p % WIDTH_DEF] = 1'b1;
        e.c = e.c + 10'd1;
      end
    end
    return e;
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < N; i++) mem[i] = v;
  endtask

  // Runs one scan window. Edge 0 is the edge that takes start.
  // p1/p2 are edges at which start is pulsed again.
  task automatic run_scan(input bit do_start, input int p1,
                          input int p2, output int lat,
                          output int addr_bad);
    lat = -1;
    addr_bad = 0;
    if (do_start) begin
      @(negedge slow_clk);
      bus.start = 1'b1;
    end
    for (int e = 0; e <= N + 20; e++) begin
      @(negedge slow_clk);
      bus.start = (e + 1 == p1) || (e + 1 == p2);
      if (e < N && bus.rd_addr !== 11'(e)) addr_bad++;
      if (e == N && bus.rd_addr !== 11'(N - 1)) addr_bad++;
      if (bus.done === 1'b1) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    dbnc_rst = 1'b1;
    bus.start = 1'b0;
    fill(8'd0);
    repeat (3) @(negedge slow_clk);
    n_checks++;
    if (bus.rd_addr !== 11'd0) begin
      n_fail++;
      $display("FAIL reset rd_addr: got %0d want 0", bus.rd_addr);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset busy: got %b want 0", bus.busy);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset done: got %b want 0", bus.done);
    end
    n_checks++;
    if (bus.mask !== '0) begin
      n_fail++;
      $display("FAIL reset mask: got %h want 0", bus.mask);
    end
    n_checks++;
    if (bus.mask_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset mask_valid: got %b want 0",
               bus.mask_valid);
    end
    n_checks++;
    if (bus.green_count !== 10'd0) begin
      n_fail++;
      $display("FAIL reset green_count: got %0d want 0",
               bus.green_count);
    end
    dbnc_rst = 1'b0;
    @(negedge slow_clk);
  endtask

  task automatic test_all_zero();
    int lat, bad;
    fill(8'd0);
    exp_q.push_back(model());
    run_scan(1'b1, -1, -1, lat, bad);
    ex = exp_q.pop_front();
    n_checks++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL zero latency: got %0d want %0d", lat, LAT);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL zero rd_addr seq: got %0d bad want 0", bad);
    end
    n_checks++;
    if (bus.mask !== '0 || bus.mask !== ex.m) begin
      n_fail++;
      $display("FAIL zero mask: got %h want 0", bus.mask);
    end
    n_checks++;
    if (bus.green_count !== 10'd0) begin
      n_fail++;
      $display("FAIL zero count: got %0d want 0",
               bus.green_count);
    end
    n_checks++;
    if (bus.mask_valid !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero status: got valid=%b busy=%b want 1 0",
               bus.mask_valid, bus.busy);
    end
    @(negedge slow_clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero done width: got %b want 0", bus.done);
    end
  endtask

  task automatic test_single_pixel();
    int lat, bad;
    fill(8'd0);
    mem[0] = 8'd30;
    mem[1] = 8'd100;
    mem[2] = 8'd100;
    exp_q.push_back(model());
    run_scan(1'b1, -1, -1, lat, bad);
    ex = exp_q.pop_front();
    n_checks++;
    if (lat !== LAT || bus.mask !== ex.m) begin
      n_fail++;
      $display("FAIL single mask: got %h lat %0d want %h lat %0d",
               bus.mask, lat, ex.m, LAT);
    end
    n_checks++;
    if (bus.mask[0][0] !== 1'b1 || bus.green_count !== 10'd1) begin
      n_fail++;
      $display("FAIL single pixel: got bit %b count %0d want 1 1",
               bus.mask[0][0], bus.green_count);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] px [5][3];
    logic       want [5];
    int lat, bad;
    px = '{'{8'd18, 8'd25, 8'd25}, '{8'd43, 8'd255, 8'd255},
           '{8'd17, 8'd25, 8'd25}, '{8'd44, 8'd100, 8'd100},
           '{8'd30, 8'd24, 8'd100}};
    want = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int t = 0; t < 5; t++) begin
      fill(8'd0);
      for (int c = 0; c < 3; c++) mem[(NPX - 1) * 3 + c] = px[t][c];
      exp_q.push_back(model());
      run_scan(1'b1, -1, -1, lat, bad);
      ex = exp_q.pop_front();
      n_checks++;
      if (bus.mask[19][29] !== want[t]
          || bus.mask !== ex.m || lat !== LAT) begin
        n_fail++;
        $display("FAIL boundary %0d: got bit %b lat %0d want %b %0d",
                 t, bus.mask[19][29], lat, want[t], LAT);
      end
      n_checks++;
      if (bus.green_count !== {9'd0, want[t]}) begin
        n_fail++;
        $display("FAIL boundary %0d count: got %0d want %0d",
                 t, bus.green_count, want[t]);
      end
    end
  endtask

  task automatic test_all_green();
    int lat, bad;
    for (int p = 0; p < NPX; p++) begin
      mem[3*p]   = 8'd30;
      mem[3*p+1] = 8'd200;
      mem[3*p+2] = 8'd200;
    end
    exp_q.push_back(model());
    run_scan(1'b1, -1, -1, lat, bad);
    ex = exp_q.pop_front();
    n_checks++;
    if (bus.mask !== {NPX{1'b1}} || bus.mask !== ex.m) begin
      n_fail++;
      $display("FAIL all green mask: got %h want all ones",
               bus.mask);
    end
    n_checks++;
    if (bus.green_count !== 10'd600) begin
      n_fail++;
      $display("FAIL all green count: got %0d want 600",
               bus.green_count);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat, bad, seen;
    fill(8'd30);
    @(negedge slow_clk);
    bus.start = 1'b1;
    for (int e = 0; e < 900; e++) begin
      @(negedge slow_clk);
      bus.start = 1'b0;
    end
    dbnc_rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.rd_addr !== 11'd0) begin
      n_fail++;
      $display("FAIL midreset: got busy=%b rd_addr=%0d want 0 0",
               bus.busy, bus.rd_addr);
    end
    n_checks++;
    if (bus.mask_valid !== 1'b0 || bus.mask !== '0) begin
      n_fail++;
      $display("FAIL midreset result: got valid=%b mask=%h want 0",
               bus.mask_valid, bus.mask);
    end
    repeat (2) @(negedge slow_clk);
    dbnc_rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge slow_clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midreset quiet: got %0d active cycles want 0",
               seen);
    end
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(10, 60));
    exp_q.push_back(model());
    run_scan(1'b1, -1, -1, lat, bad);
    ex = exp_q.pop_front();
    n_checks++;
    if (lat !== LAT || bad !== 0 || bus.mask !== ex.m
        || bus.green_count !== ex.c) begin
      n_fail++;
      $display("FAIL after reset scan: got lat %0d cnt %0d want %0d %0d",
               lat, bus.green_count, LAT, ex.c);
    end
  endtask

  task automatic test_restart_ignored();
    int lat, bad, extra;
    mask_t held;
    for (int i = 0; i < N; i++)
      mem[i] = (i % 3 == 0) ? 8'($urandom_range(10, 50))
                            : 8'($urandom_range(0, 255));
    exp_q.push_back(model());
    run_scan(1'b1, 5, LAT, lat, bad);
    ex = exp_q.pop_front();
    n_checks++;
    if (lat !== LAT || bad !== 0) begin
      n_fail++;
      $display("FAIL restart ignored: got lat %0d bad %0d want %0d 0",
               lat, bad, LAT);
    end
    n_checks++;
    if (bus.mask !== ex.m || bus.green_count !== ex.c) begin
      n_fail++;
      $display("FAIL restart result: got cnt %0d want %0d",
               bus.green_count, ex.c);
    end
    held = bus.mask;
    extra = 0;
    repeat (20) begin
      @(negedge slow_clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0
          || bus.rd_addr !== 11'd0 || bus.mask !== held
          || bus.mask_valid !== 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL restart idle hold: got %0d bad cycles want 0",
               extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, bad1, bad2;
    for (int i = 0; i < N; i++)
      mem[i] = (i % 3 == 0) ? 8'($urandom_range(15, 46))
                            : 8'($urandom_range(20, 255));
    exp_q.push_back(model());
    exp_q.push_back(model());
    run_scan(1'b1, LAT + 1, -1, lat1, bad1);
    ex = exp_q.pop_front();
    n_checks++;
    if (lat1 !== LAT || bus.mask !== ex.m
        || bus.green_count !== ex.c) begin
      n_fail++;
      $display("FAIL b2b first: got lat %0d cnt %0d want %0d %0d",
               lat1, bus.green_count, LAT, ex.c);
    end
    run_scan(1'b0, -1, -1, lat2, bad2);
    ex = exp_q.pop_front();
    n_checks++;
    if (lat2 !== LAT || bad2 !== 0) begin
      n_fail++;
      $display("FAIL b2b second: got lat %0d bad %0d want %0d 0",
               lat2, bad2, LAT);
    end
    n_checks++;
    if (bus.mask !== ex.m || bus.green_count !== ex.c) begin
      n_fail++;
      $display("FAIL b2b second result: got cnt %0d want %0d",
               bus.green_count, ex.c);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    bus.start = 1'b0;
    dbnc_rst = 1'b1;
    test_reset();
    test_all_zero();
    test_single_pixel();
    test_boundary();
    test_all_green();
    test_reset_mid_scan();
    test_restart_ignored();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
